// File: rtl/data_memory_pkg.sv
// Shared types, default widths and the byte-merge helper for the data memory block.
package data_memory_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    CLR_PEND
  } state_t;

  // One byte lane of a masked write: take the new byte only where its enable is set.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between the core's memory stage and data_memory_ctrl.
interface data_memory_if #(
  parameter int DATA_W = data_memory_pkg::DEF_DATA_W,
  parameter int ADDR_W = data_memory_pkg::DEF_ADDR_W
);

  logic                  clear_req;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  wr_err;
  logic                  busy;

  modport master (
    output clear_req, req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err, busy
  );

  modport slave (
    input  clear_req, req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err, busy
  );

endinterface

// File: rtl/data_memory_ram.sv
// Single-port storage array with per-byte write enables and a registered read,
// written in a form that maps onto block RAM.
module data_memory_ram
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on reads so the controller can rely on it holding between responses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
          mem[addr][8*i +: 8] <= merge_byte(mem[addr][8*i +: 8], wdata[8*i +: 8], be[i]);
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: clear engine, request acceptance, range checking and
// the optional output register around data_memory_ram.
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic                ready_q;
  logic                busy_q;

  logic                accept;
  logic                in_range;
  logic                rd_accept;
  logic                wr_accept;
  logic                clr_write;
  logic                pipe_busy;

  logic                ram_en;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [BE_W-1:0]     ram_be;
  logic [DATA_W-1:0]   ram_rdata;

  logic                rd_v1;
  logic                rd_err1;
  logic                zero_rdata;
  logic                wr_err_q;
  logic [DATA_W-1:0]   s1_rdata;

  // Range check is done one bit wider than the address so DEPTH == 2**ADDR_W works.
  always_comb begin
    accept    = bus.req_valid & ready_q & rst_n;
    in_range  = ({1'b0, bus.req_addr} < DEPTH_EXT);
    rd_accept = accept & ~bus.req_write;
    wr_accept = accept & bus.req_write;
    clr_write = (state == CLEAR) & rst_n;
    ram_en    = clr_write | (accept & in_range);
    ram_we    = clr_write | wr_accept;
    ram_addr  = clr_write ? clr_ptr : bus.req_addr;
    ram_wdata = clr_write ? '0 : bus.req_wdata;
    ram_be    = clr_write ? '1 : bus.req_be;
  end

  data_memory_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == LAST_ADDR) begin
            state   <= IDLE;
            clr_ptr <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          // A read accepted alongside clear_req still counts as in flight.
          if (bus.clear_req) begin
            state   <= (pipe_busy | rd_accept) ? CLR_PEND : CLEAR;
            clr_ptr <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CLR_PEND: begin
          if (!pipe_busy) begin
            state <= CLEAR;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // zero_rdata masks the stale RAM output after reset and after out-of-range reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v1      <= 1'b0;
      rd_err1    <= 1'b0;
      zero_rdata <= 1'b1;
      wr_err_q   <= 1'b0;
    end else begin
      rd_v1    <= rd_accept;
      rd_err1  <= rd_accept & ~in_range;
      wr_err_q <= wr_accept & ~in_range;
      if (rd_accept) begin
        zero_rdata <= ~in_range;
      end
    end
  end

  assign s1_rdata = zero_rdata ? '0 : ram_rdata;

  if (OUT_REG != 0) begin : g_out_reg
    logic              rd_v2;
    logic              rd_err2;
    logic [DATA_W-1:0] rdata2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_v2   <= 1'b0;
        rd_err2 <= 1'b0;
        rdata2  <= '0;
      end else begin
        rd_v2   <= rd_v1;
        rd_err2 <= rd_err1;
        if (rd_v1) begin
          rdata2 <= s1_rdata;
        end
      end
    end

    assign pipe_busy     = rd_v1 | rd_v2;
    assign bus.rsp_valid = rd_v2;
    assign bus.rsp_err   = rd_err2;
    assign bus.rsp_rdata = rdata2;
  end else begin : g_no_out_reg
    assign pipe_busy     = rd_v1;
    assign bus.rsp_valid = rd_v1;
    assign bus.rsp_err   = rd_err1;
    assign bus.rsp_rdata = s1_rdata;
  end

  assign bus.req_ready = ready_q & rst_n;
  assign bus.busy      = busy_q | ~rst_n;
  assign bus.wr_err    = wr_err_q;

endmodule
